// File: rtl/usb_stream_gen_chk.sv
`default_nettype none
// ============================================================================
// Module   : usb_stream_gen_chk
// Purpose  : Endpoint traffic generator (const / increment / PRBS, burst+gap)
//            and loopback checker with byte and error counters.
// Revision : 1.0
// ============================================================================
module usb_stream_gen_chk #(
    parameter int          DATA_W  = 8,
    parameter int          CNT_W   = 32,
    parameter int          BURST_W = 12,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    input  logic [DATA_W-1:0]  i_const,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic [BURST_W-1:0] i_gap,
    input  logic               i_clear,
    input  logic               i_tx_rdy,
    output logic               o_tx_dval,
    output logic [DATA_W-1:0]  o_tx_data,
    input  logic               i_rx_dval,
    input  logic [DATA_W-1:0]  i_rx_data,
    output logic [CNT_W-1:0]   o_tx_count,
    output logic [CNT_W-1:0]   o_rx_count,
    output logic [CNT_W-1:0]   o_err_count,
    output logic               o_err,
    output logic [DATA_W-1:0]  o_first_err
);

    localparam logic [1:0] c_MODE_CONST = 2'd0;
    localparam logic [1:0] c_MODE_INC   = 2'd1;
    localparam logic [1:0] c_MODE_PRBS  = 2'd2;
    localparam logic [1:0] c_MODE_OFF   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // ------------------------------------------------------------------ TX
    tx_state_t          r_tx_state;
    logic [1:0]         r_mode;
    logic [DATA_W-1:0]  r_const;
    logic [BURST_W-1:0] r_burst_len;
    logic [BURST_W-1:0] r_gap;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] r_gap_cnt;
    logic [15:0]        r_lfsr;
    logic               r_tx_dval;
    logic [DATA_W-1:0]  r_tx_data;
    logic [CNT_W-1:0]   r_tx_count;

    logic               w_xfer;
    logic               w_burst_last;
    logic [15:0]        w_lfsr_nxt;
    logic [DATA_W-1:0]  w_pat_nxt;
    logic [DATA_W-1:0]  w_pat_start;

    assign w_xfer       = r_tx_dval && i_tx_rdy;
    assign w_burst_last = (r_burst_cnt == r_burst_len - BURST_W'(1));
    assign w_lfsr_nxt   = lfsr_next(r_lfsr);

    always_comb begin
        w_pat_nxt   = r_const;
        w_pat_start = i_const;
        case (r_mode)
            c_MODE_INC:  w_pat_nxt = r_tx_data + DATA_W'(1);
            c_MODE_PRBS: w_pat_nxt = w_lfsr_nxt[DATA_W-1:0];
            default:     w_pat_nxt = r_const;
        endcase
        case (i_mode)
            c_MODE_INC:  w_pat_start = '0;
            c_MODE_PRBS: w_pat_start = SEED[DATA_W-1:0];
            default:     w_pat_start = i_const;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_state  <= ST_IDLE;
            r_mode      <= c_MODE_CONST;
            r_const     <= '0;
            r_burst_len <= '0;
            r_gap       <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_lfsr      <= SEED;
            r_tx_dval   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_count  <= '0;
        end else begin
            if (i_clear)
                r_tx_count <= '0;
            else if (w_xfer)
                r_tx_count <= r_tx_count + CNT_W'(1);

            if (w_xfer) begin
                r_tx_data <= w_pat_nxt;
                r_lfsr    <= w_lfsr_nxt;
            end

            case (r_tx_state)
                ST_IDLE: begin
                    if (i_enable && i_mode != c_MODE_OFF) begin
                        r_mode      <= i_mode;
                        r_const     <= i_const;
                        r_burst_len <= i_burst_len;
                        r_gap       <= i_gap;
                        r_burst_cnt <= '0;
                        r_tx_data   <= w_pat_start;
                        r_lfsr      <= SEED;
                        r_tx_dval   <= 1'b1;
                        r_tx_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_xfer && r_burst_len != '0) begin
                        if (w_burst_last) begin
                            r_burst_cnt <= '0;
                            if (r_gap != '0) begin
                                r_gap_cnt  <= '0;
                                r_tx_dval  <= 1'b0;
                                r_tx_state <= ST_GAP;
                            end
                        end else begin
                            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == r_gap - BURST_W'(1)) begin
                        r_tx_dval  <= 1'b1;
                        r_tx_state <= ST_RUN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + BURST_W'(1);
                    end
                end
                default: begin
                    r_tx_dval  <= 1'b0;
                    r_tx_state <= ST_IDLE;
                end
            endcase

            // Dropping enable wins over every other transition.
            if (!i_enable) begin
                r_tx_dval  <= 1'b0;
                r_tx_state <= ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------- Checker
    logic               r_hunt;
    logic [DATA_W-1:0]  r_exp;
    logic [15:0]        r_chk_lfsr;
    logic [CNT_W-1:0]   r_rx_count;
    logic [CNT_W-1:0]   r_err_count;
    logic               r_err;
    logic [DATA_W-1:0]  r_first_err;

    logic               w_rx_act;
    logic               w_cmp;
    logic [DATA_W-1:0]  w_exp;
    logic               w_mismatch;

    assign w_rx_act = i_rx_dval && (i_mode != c_MODE_OFF);

    always_comb begin
        w_exp = i_const;
        w_cmp = 1'b0;
        case (i_mode)
            c_MODE_CONST: begin w_exp = i_const;                   w_cmp = 1'b1;    end
            c_MODE_INC:   begin w_exp = r_exp;                     w_cmp = !r_hunt; end
            c_MODE_PRBS:  begin w_exp = r_chk_lfsr[DATA_W-1:0];    w_cmp = 1'b1;    end
            default:      begin w_exp = i_const;                   w_cmp = 1'b0;    end
        endcase
    end

    assign w_mismatch = w_rx_act && w_cmp && (i_rx_data != w_exp);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hunt      <= 1'b1;
            r_exp       <= '0;
            r_chk_lfsr  <= SEED;
            r_rx_count  <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
            r_first_err <= '0;
        end else if (i_clear) begin
            r_hunt      <= 1'b1;
            r_exp       <= '0;
            r_chk_lfsr  <= SEED;
            r_rx_count  <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
            r_first_err <= '0;
        end else begin
            if (w_rx_act) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
                // Expected value free-runs once locked, even across mismatches.
                if (i_mode == c_MODE_INC) begin
                    r_exp  <= (r_hunt ? i_rx_data : r_exp) + DATA_W'(1);
                    r_hunt <= 1'b0;
                end
                if (i_mode == c_MODE_PRBS)
                    r_chk_lfsr <= lfsr_next(r_chk_lfsr);
            end
            if (w_mismatch) begin
                if (r_err_count != '1)
                    r_err_count <= r_err_count + CNT_W'(1);
                if (!r_err) begin
                    r_err       <= 1'b1;
                    r_first_err <= i_rx_data;
                end
            end
        end
    end

    assign o_tx_dval   = r_tx_dval;
    assign o_tx_data   = r_tx_data;
    assign o_tx_count  = r_tx_count;
    assign o_rx_count  = r_rx_count;
    assign o_err_count = r_err_count;
    assign o_err       = r_err;
    assign o_first_err = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_stream_gen_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_stream_gen_chk
// Purpose  : Directed self-checking bench for usb_stream_gen_chk.
// Revision : 1.0
// ============================================================================
module tb_usb_stream_gen_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  cnst = 8'h00;
    logic [11:0] burst_len = '0;
    logic [11:0] gap = '0;
    logic        clear = 1'b0;
    logic        tx_rdy = 1'b0;
    logic        loop_en = 1'b0;
    logic        corrupt = 1'b0;
    logic        man_dval = 1'b0;
    logic [7:0]  man_data = 8'h00;

    logic        tx_dval;
    logic [7:0]  tx_data;
    logic        rx_dval;
    logic [7:0]  rx_data;
    logic [31:0] tx_count, rx_count, err_count;
    logic        err;
    logic [7:0]  first_err;

    int n_checks = 0;
    int n_errors = 0;

    assign rx_dval = loop_en ? (tx_dval & tx_rdy) : man_dval;
    assign rx_data = loop_en ? (corrupt ? 8'h55 : tx_data) : man_data;

    always #5 clk = ~clk;

    usb_stream_gen_chk dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_mode      (mode),
        .i_const     (cnst),
        .i_burst_len (burst_len),
        .i_gap       (gap),
        .i_clear     (clear),
        .i_tx_rdy    (tx_rdy),
        .o_tx_dval   (tx_dval),
        .o_tx_data   (tx_data),
        .i_rx_dval   (rx_dval),
        .i_rx_data   (rx_data),
        .o_tx_count  (tx_count),
        .o_rx_count  (rx_count),
        .o_err_count (err_count),
        .o_err       (err),
        .o_first_err (first_err)
    );

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_dval !== 1'b0) begin n_errors++; $display("FAIL reset_dval got=%b want=0", tx_dval); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got=%h want=00", tx_data); end
        n_checks++; if (tx_count !== 32'd0) begin n_errors++; $display("FAIL reset_tx_count got=%0d want=0", tx_count); end
        n_checks++; if (rx_count !== 32'd0) begin n_errors++; $display("FAIL reset_rx_count got=%0d want=0", rx_count); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", err); end
        n_checks++; if (first_err !== 8'h00) begin n_errors++; $display("FAIL reset_first_err got=%h want=00", first_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_dval !== 1'b0) begin n_errors++; $display("FAIL idle_dval got=%b want=0", tx_dval); end
    endtask

    task automatic test_mode_off();
        mode = 2'd3; enable = 1'b1; loop_en = 1'b0;
        man_dval = 1'b1; man_data = 8'h12;
        repeat (4) @(negedge clk);
        n_checks++; if (tx_dval !== 1'b0) begin n_errors++; $display("FAIL off_dval got=%b want=0", tx_dval); end
        n_checks++; if (rx_count !== 32'd0) begin n_errors++; $display("FAIL off_rx_count got=%0d want=0", rx_count); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL off_err_count got=%0d want=0", err_count); end
        man_dval = 1'b0; enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_const();
        pulse_clear();
        mode = 2'd0; cnst = 8'hEF; burst_len = '0; gap = '0; tx_rdy = 1'b1; loop_en = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx_dval !== 1'b1 || tx_data !== 8'hEF) begin
                n_errors++; $display("FAIL const_byte%0d got=%b/%h want=1/ef", k, tx_dval, tx_data);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_dval !== 1'b0) begin n_errors++; $display("FAIL const_stop_dval got=%b want=0", tx_dval); end
        n_checks++; if (tx_count !== 32'd100) begin n_errors++; $display("FAIL const_tx_count got=%0d want=100", tx_count); end
        n_checks++; if (rx_count !== 32'd100) begin n_errors++; $display("FAIL const_rx_count got=%0d want=100", rx_count); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL const_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_increment_backpressure();
        logic [7:0] exp;
        int nx;
        exp = 8'h00; nx = 0;
        tx_rdy = 1'b0; loop_en = 1'b1; mode = 2'd1; burst_len = '0; gap = '0;
        pulse_clear();
        enable = 1'b1;
        for (int k = 0; k < 520; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx_dval !== 1'b1 || tx_data !== exp) begin
                n_errors++; $display("FAIL inc_step%0d got=%b/%h want=1/%h", k, tx_dval, tx_data, exp);
            end
            tx_rdy = (k % 2 == 0);
            if (tx_rdy) begin exp = exp + 8'd1; nx++; end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        tx_rdy = 1'b1;
        n_checks++; if (tx_count !== 32'(nx)) begin n_errors++; $display("FAIL inc_tx_count got=%0d want=%0d", tx_count, nx); end
        n_checks++; if (rx_count !== 32'(nx)) begin n_errors++; $display("FAIL inc_rx_count got=%0d want=%0d", rx_count, nx); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL inc_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_prbs();
        logic [7:0] first3 [3];
        first3[0] = 8'hE1; first3[1] = 8'hC3; first3[2] = 8'h87;
        mode = 2'd2; tx_rdy = 1'b1; loop_en = 1'b1;
        pulse_clear();
        enable = 1'b1;
        for (int k = 1; k <= 10000; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                n_checks++;
                if (tx_dval !== 1'b1 || tx_data !== first3[k-1]) begin
                    n_errors++; $display("FAIL prbs_byte%0d got=%b/%h want=1/%h", k-1, tx_dval, tx_data, first3[k-1]);
                end
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_count !== 32'd10000) begin n_errors++; $display("FAIL prbs_tx_count got=%0d want=10000", tx_count); end
        n_checks++; if (rx_count !== 32'd10000) begin n_errors++; $display("FAIL prbs_rx_count got=%0d want=10000", rx_count); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL prbs_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_burst_gap();
        logic [7:0] exp;
        logic       exp_dval;
        int nx;
        exp = 8'h00; nx = 0;
        mode = 2'd1; burst_len = 12'd4; gap = 12'd3; tx_rdy = 1'b1; loop_en = 1'b1;
        pulse_clear();
        enable = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if (k == 0) begin burst_len = '0; gap = '0; end  // must be ignored while running
            exp_dval = ((k % 7) < 4);
            n_checks++;
            if (tx_dval !== exp_dval) begin
                n_errors++; $display("FAIL burst_dval%0d got=%b want=%b", k, tx_dval, exp_dval);
            end
            if (exp_dval) begin
                n_checks++;
                if (tx_data !== exp) begin
                    n_errors++; $display("FAIL burst_data%0d got=%h want=%h", k, tx_data, exp);
                end
                exp = exp + 8'd1; nx++;
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_count !== 32'(nx)) begin n_errors++; $display("FAIL burst_tx_count got=%0d want=%0d", tx_count, nx); end
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL burst_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_checker_error();
        mode = 2'd1; burst_len = '0; gap = '0; tx_rdy = 1'b1; loop_en = 1'b1;
        pulse_clear();
        enable = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            corrupt = (k == 21) || (k == 41);   // bytes 20 and 40
            if (k == 30) begin
                n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err1_flag got=%b want=1", err); end
                n_checks++; if (err_count !== 32'd1) begin n_errors++; $display("FAIL err1_count got=%0d want=1", err_count); end
                n_checks++; if (first_err !== 8'h55) begin n_errors++; $display("FAIL err1_first got=%h want=55", first_err); end
            end
        end
        enable = 1'b0; corrupt = 1'b0;
        @(negedge clk);
        n_checks++; if (err_count !== 32'd2) begin n_errors++; $display("FAIL err2_count got=%0d want=2", err_count); end
        n_checks++; if (first_err !== 8'h55) begin n_errors++; $display("FAIL err2_first got=%h want=55", first_err); end
        n_checks++; if (rx_count !== 32'd50) begin n_errors++; $display("FAIL err2_rx_count got=%0d want=50", rx_count); end
        loop_en = 1'b0;
        pulse_clear();
        n_checks++; if (err_count !== 32'd0 || rx_count !== 32'd0 || tx_count !== 32'd0) begin
            n_errors++; $display("FAIL clear_counts got=%0d/%0d/%0d want=0/0/0", err_count, rx_count, tx_count);
        end
        n_checks++; if (err !== 1'b0 || first_err !== 8'h00) begin
            n_errors++; $display("FAIL clear_err got=%b/%h want=0/00", err, first_err);
        end
        man_dval = 1'b1; man_data = 8'h80;
        @(negedge clk); man_data = 8'h81;
        @(negedge clk); man_data = 8'h83;
        n_checks++; if (err_count !== 32'd0) begin n_errors++; $display("FAIL rehunt_lock got=%0d want=0", err_count); end
        @(negedge clk); man_dval = 1'b0;
        @(negedge clk);
        n_checks++; if (err_count !== 32'd1) begin n_errors++; $display("FAIL rehunt_err got=%0d want=1", err_count); end
        n_checks++; if (first_err !== 8'h83) begin n_errors++; $display("FAIL rehunt_first got=%h want=83", first_err); end
        n_checks++; if (rx_count !== 32'd3) begin n_errors++; $display("FAIL rehunt_rx_count got=%0d want=3", rx_count); end
    endtask

    task automatic test_reset_midburst();
        mode = 2'd1; burst_len = '0; gap = '0; tx_rdy = 1'b1; loop_en = 1'b1;
        pulse_clear();
        enable = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_dval !== 1'b0) begin n_errors++; $display("FAIL rst_async_dval got=%b want=0", tx_dval); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL rst_async_data got=%h want=00", tx_data); end
        n_checks++; if (tx_count !== 32'd0 || rx_count !== 32'd0) begin
            n_errors++; $display("FAIL rst_async_counts got=%0d/%0d want=0/0", tx_count, rx_count);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_dval !== 1'b1 || tx_data !== 8'h00) begin
            n_errors++; $display("FAIL rst_restart0 got=%b/%h want=1/00", tx_dval, tx_data);
        end
        @(negedge clk);
        n_checks++; if (tx_data !== 8'h01) begin n_errors++; $display("FAIL rst_restart1 got=%h want=01", tx_data); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mode_off();
        test_const();
        test_increment_backpressure();
        test_prbs();
        test_burst_gap();
        test_checker_error();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
